mat_vec_engine: RTL

Parametrised matrix-vector multiply engine: computes y = A·b for a ROWS×COLS matrix A and a COLS-element vector b. Operands are loaded over valid/ready streams and computed on a skewed MAC array, one MAC per row. The ROWS results are presented in parallel behind a valid/ready handshake. It is the general-size, signed-capable, accumulate-capable replacement for the fixed 8×8 matrix-vector multiplier in the accelerator datapath.

---
 rtl/mvm_pkg.sv | 21 ++
 rtl/mvm_mac.sv | 41 ++++
 rtl/mat_vec_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// Shared state encoding and arithmetic helpers for the matrix-vector engine.
package mvm_pkg;

   typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

   localparam int EXT_W = 64;

   function automatic int acc_min_width(input int data_width, input int cols);
      return 2 * data_width + $clog2(cols);
   endfunction

   // Widen the w-bit value in the low bits of v, filling with its sign bit when sgn is set.
   function automatic logic [EXT_W-1:0] extend(input logic [EXT_W-1:0] v, input int w, input bit sgn);
      logic [EXT_W-1:0] mask;
      mask = (w >= EXT_W) ? '1 : ((EXT_W'(1) << w) - EXT_W'(1));
      if (sgn && (((v >> (w - 1)) & EXT_W'(1)) != '0))
         return v | ~mask;
      return v & mask;
   endfunction

endpackage

// File: rtl/mvm_mac.sv
// One row of the MAC array: registered accumulator fed by a widened product.
// clr wins over everything; on an enabled cycle load replaces the sum, otherwise the product is added.
module mvm_mac
   import mvm_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24,
   parameter int SIGNED     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  load,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc
);
   localparam int PW = 2 * DATA_WIDTH;

   logic [PW-1:0]        a_x;
   logic [PW-1:0]        b_x;
   logic [PW-1:0]        prod;
   logic [ACC_WIDTH-1:0] prod_x;

   // With sign-extended operands the low 2*DATA_WIDTH bits are the exact signed product.
   assign a_x    = (SIGNED != 0) ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} : {{DATA_WIDTH{1'b0}}, a};
   assign b_x    = (SIGNED != 0) ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b} : {{DATA_WIDTH{1'b0}}, b};
   assign prod   = a_x * b_x;
   assign prod_x = ACC_WIDTH'(extend(EXT_W'(prod), PW, SIGNED != 0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= load ? prod_x : acc + prod_x;
   end

endmodule

// File: rtl/mat_vec_engine.sv
// y = A*b on a skewed per-row MAC array; RUN lasts ROWS+COLS-1 cycles after the last A/b beat.
// a_ready/b_ready drop outside LOAD; DONE holds res_data stable until res_ready is seen.
module mat_vec_engine
   import mvm_pkg::*;
#(
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int DATA_WIDTH = 8,
   parameter int SIGNED     = 0,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            a_valid,
   output logic                            a_ready,
   input  logic [ROWS-1:0][DATA_WIDTH-1:0] a_data,
   input  logic                            b_valid,
   output logic                            b_ready,
   input  logic [DATA_WIDTH-1:0]           b_data,
   input  logic                            accumulate,
   input  logic                            clr,
   output logic                            busy,
   output logic                            done,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [ROWS-1:0][ACC_WIDTH-1:0]  res_data
);
   localparam int            CW       = $clog2(COLS + 1);
   localparam int            KW       = $clog2(ROWS + COLS);
   localparam logic [CW-1:0] CNT_FULL = CW'(COLS);
   localparam logic [KW-1:0] K_LAST   = KW'(ROWS + COLS - 2);

   if (ACC_WIDTH < acc_min_width(DATA_WIDTH, COLS)) begin : g_acc_width_check
      $error("mat_vec_engine: ACC_WIDTH too narrow for DATA_WIDTH and COLS");
   end

   state_t                state;
   state_t                state_nxt;
   logic [CW-1:0]         a_cnt;
   logic [CW-1:0]         b_cnt;
   logic [KW-1:0]         k;
   logic                  acc_mode;
   logic                  done_q;
   logic                  a_take;
   logic                  b_take;
   logic                  load_done;
   logic                  start;
   logic                  clr_load;
   logic [DATA_WIDTH-1:0] a_buf [ROWS][COLS];
   logic [DATA_WIDTH-1:0] b_buf [COLS];
   logic [DATA_WIDTH-1:0] skew  [ROWS];
   logic [DATA_WIDTH-1:0] b_first;
   logic [DATA_WIDTH-1:0] b_next;

   assign a_ready   = (state == LOAD) && (a_cnt != CNT_FULL);
   assign b_ready   = (state == LOAD) && (b_cnt != CNT_FULL);
   assign a_take    = a_valid && a_ready;
   assign b_take    = b_valid && b_ready;
   assign load_done = ((a_cnt + CW'(a_take)) == CNT_FULL) && ((b_cnt + CW'(b_take)) == CNT_FULL);
   assign start     = (state == LOAD) && load_done;
   assign clr_load  = clr && (state == LOAD);
   assign busy      = (state == RUN);
   assign res_valid = (state == DONE);
   assign done      = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= LOAD;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (load_done)   state_nxt = RUN;
         RUN:     if (k == K_LAST) state_nxt = DONE;
         DONE:    if (res_ready)   state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // The final b beat can land on the LOAD->RUN edge itself, so stage 0 bypasses the buffer.
   always_comb begin
      b_first = (b_take && (b_cnt == '0)) ? b_data : b_buf[0];
      b_next  = '0;
      for (int j = 1; j < COLS; j++)
         if (k == KW'(j - 1)) b_next = b_buf[j];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_cnt    <= '0;
         b_cnt    <= '0;
         k        <= '0;
         acc_mode <= 1'b0;
         done_q   <= 1'b0;
         for (int j = 0; j < COLS; j++) begin
            b_buf[j] <= '0;
            for (int i = 0; i < ROWS; i++) a_buf[i][j] <= '0;
         end
         for (int i = 0; i < ROWS; i++) skew[i] <= '0;
      end else begin
         done_q <= (state == RUN) && (k == K_LAST);
         if (a_take) begin
            a_cnt <= a_cnt + CW'(1);
            for (int j = 0; j < COLS; j++)
               if (a_cnt == CW'(j))
                  for (int i = 0; i < ROWS; i++) a_buf[i][j] <= a_data[i];
         end
         if (b_take) begin
            b_cnt <= b_cnt + CW'(1);
            for (int j = 0; j < COLS; j++)
               if (b_cnt == CW'(j)) b_buf[j] <= b_data;
         end
         if (start) begin
            acc_mode <= accumulate;
            k        <= '0;
            skew[0]  <= b_first;
            for (int i = 1; i < ROWS; i++) skew[i] <= '0;
         end else if (state == RUN) begin
            k       <= k + KW'(1);
            skew[0] <= b_next;
            for (int i = 1; i < ROWS; i++) skew[i] <= skew[i-1];
         end
         if ((state == DONE) && res_ready) begin
            a_cnt <= '0;
            b_cnt <= '0;
         end
      end
   end

   // Row i works on column k-i, so it is live for k in [i, i+COLS-1].
   for (genvar i = 0; i < ROWS; i++) begin : g_row
      logic                  en;
      logic                  first;
      logic [DATA_WIDTH-1:0] a_op;

      always_comb begin
         en   = 1'b0;
         a_op = '0;
         for (int j = 0; j < COLS; j++)
            if ((state == RUN) && (k == KW'(i + j))) begin
               en   = 1'b1;
               a_op = a_buf[i][j];
            end
      end

      assign first = (k == KW'(i)) && !acc_mode;

      mvm_mac #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH),
         .SIGNED     (SIGNED)
      ) u_mac (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .load  (first),
         .clr   (clr_load),
         .a     (a_op),
         .b     (skew[i]),
         .acc   (res_data[i])
      );
   end

endmodule
